latch_mutex_arbiter: RTL and testbench
======================================

Name: latch_mutex_arbiter

Overview:
Clocked round-robin mutual-exclusion arbiter that shares one resource among N requesters. The resource is typically a bank of sr_latch/lut cells, and each requester is a self-timed stage. Requests arrive asynchronously and are synchronised before use. Grants follow a four-phase req/gnt handshake, with guard cycles between owners so latch outputs settle, and an optional hold timeout that revokes a stuck owner.

Parameters:
N, 4, number of requesters (N >= 2)
SYNC_STAGES, 2, flops per request synchroniser (>= 1)
GUARD, 1, idle cycles inserted after each release before next grant (0 allowed)
TIMEOUT, 0, max cycles a grant may be held; 0 disables timeout

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low (rst=0 => reset)
req  in  N  per-requester request level, asynchronous to clk
err_clr  in  1  synchronous clear of err
gnt  out  N  one-hot grant, registered
owner  out  max(1,$clog2(N))  index of current/last granted requester
busy  out  1  high whenever state != IDLE
err  out  1  sticky timeout flag

Behaviour:
- Reset (rst=0, async): sync flops=0, gnt=0, owner=0, busy=0, err=0, rr pointer ptr=0, timer=0, state=IDLE.
- req_s = req delayed through SYNC_STAGES flops. Only req_s is used for decisions.
- States: IDLE, GRANT, REVOKE, GUARD.
- IDLE:
  - If any req_s bit is set, select the first set bit searching ptr, ptr+1, ... mod N.
  - Register owner=sel and gnt=onehot(sel); go to GRANT.
  - Latency: req rise to gnt rise = SYNC_STAGES+1 clk edges.
- GRANT:
  - gnt held while req_s[owner]=1. Timer counts up from 0 on grant entry.
  - On req_s[owner]=0: gnt=0 on the next edge, ptr=(owner+1) mod N, go to GUARD (or IDLE if GUARD=0).
  - Release latency: req fall to gnt fall = SYNC_STAGES+1 edges.
- Timeout (TIMEOUT != 0):
  - Fires when the timer reaches TIMEOUT with req_s[owner] still 1, so gnt has been high exactly TIMEOUT cycles.
  - On that edge: gnt=0, err=1, ptr=(owner+1) mod N, go to REVOKE.
- REVOKE: gnt=0. Wait for req_s[owner]=0, then go to GUARD/IDLE. No other requester is granted meanwhile.
- GUARD: gnt=0 for exactly GUARD cycles, then IDLE.
- Grant spacing: minimum idle gap between successive grants is GUARD+1 cycles, measured from the gnt-fall edge to the next gnt-rise edge.
- err: set by timeout, cleared by err_clr. Set wins when both occur on the same edge.
- Handshake rules:
  - A requester may withdraw req before it is granted; it is simply skipped.
  - Glitches shorter than one clk are either missed or seen as a full request. The requester must not depend on either outcome.
  - Non-owner requests are ignored until IDLE.
- gnt is never more than one-hot. gnt=0 in IDLE, REVOKE and GUARD.
- owner holds its last value outside GRANT.
- Reset mid-operation: gnt drops immediately (async) and ptr returns to 0.
- Timer width is $clog2(TIMEOUT+1) and saturates; no wrap.
- ptr wraps from N-1 to 0.

Test Plan:
1. SYNC_STAGES=2, GUARD=1: raise req[0] -> gnt=4'b0001 on the 3rd edge, owner=0, busy=1. Drop req[0] -> gnt=0 on the 3rd edge, busy high 1 more cycle, then 0.
2. req=4'b1111 held from reset release; each requester drops its req 5 cycles after its own gnt. Required: grants in order 0,1,2,3, each separated by exactly GUARD+1 idle cycles, gnt never multi-hot.
3. Round-robin: grant to 2 completes, then req[1] and req[3] rise on the same edge -> gnt[3] first; after its release, gnt[1].
4. TIMEOUT=8: req[1] held indefinitely with req[2]=1. Required:
   - gnt[1] high exactly 8 cycles, then err=1.
   - No grant while req[1] stays high.
   - After req[1] drops: GUARD cycle, then gnt[2].
5. err_clr pulsed on the same edge as the timeout -> err=1. err_clr one cycle later -> err=0.
6. rst=0 asserted while gnt[2]=1 -> gnt=0 before the next clk edge, owner=0. After release with req[0] and req[3] both high -> gnt[0] first.

Source files
------------

// File: rtl/latch_mutex_arbiter.sv
// latch_mutex_arbiter: round-robin mutex for N self-timed requesters.
// Requests are synchronised; grants use a guard gap and optional hold timeout.
module latch_mutex_arbiter #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int GUARD       = 1,
  parameter int TIMEOUT     = 0,
  localparam int OW = (N > 1) ? $clog2(N) : 1,
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1,
  localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          err_clr,
  output logic [N-1:0]  gnt,
  output logic [OW-1:0] owner,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_REVOKE,
    S_GUARD
  } state_e;

  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);
  localparam logic [GW-1:0] GLAST = GW'((GUARD > 0) ? GUARD - 1 : 0);
  localparam state_e        REL_ST = (GUARD > 0) ? S_GUARD : S_IDLE;

  logic [SYNC_STAGES-1:0][N-1:0] sync_q;
  logic [N-1:0]  req_s;

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          err_q, err_d;

  logic [OW-1:0] sel;
  logic [OW:0]   cand;
  logic          found;
  logic [OW-1:0] nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= req;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // first set request at or after ptr, wrapping mod N
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (OW+1)'(k);
      if (cand >= (OW+1)'(N)) begin
        cand = cand - (OW+1)'(N);
      end
      if (!found && req_s[cand[OW-1:0]]) begin
        found = 1'b1;
        sel   = cand[OW-1:0];
      end
    end
  end

  assign nxt = (owner_q == OW'(N - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    gcnt_d  = gcnt_q;
    err_d   = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          owner_d    = sel;
          gnt_d      = '0;
          gnt_d[sel] = 1'b1;
          timer_d    = '0;
          state_d    = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!req_s[owner_q]) begin
          gnt_d   = '0;
          ptr_d   = nxt;
          gcnt_d  = '0;
          state_d = REL_ST;
        end else begin
          if (timer_q != '1) begin
            timer_d = timer_q + 1'b1;
          end
          // owner still holding after TIMEOUT cycles: revoke, flag err
          if (TIMEOUT > 0 && timer_d == TMAX) begin
            gnt_d   = '0;
            err_d   = 1'b1;
            ptr_d   = nxt;
            state_d = S_REVOKE;
          end
        end
      end
      S_REVOKE: begin
        if (!req_s[owner_q]) begin
          gcnt_d  = '0;
          state_d = REL_ST;
        end
      end
      S_GUARD: begin
        if (gcnt_q == GLAST) begin
          state_d = S_IDLE;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      timer_q <= '0;
      gcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
      gcnt_q  <= gcnt_d;
      err_q   <= err_d;
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = (state_q != S_IDLE);
  assign err   = err_q;

endmodule

// File: tb/tb_latch_mutex_arbiter.sv
// Bench for latch_mutex_arbiter: directed handshake cases plus random
// requester agents scored against a transaction-level reference model.
module tb_latch_mutex_arbiter;

  localparam int N  = 4;
  localparam int SS = 2;
  localparam int GD = 1;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         err_clr = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [1:0]   owner;
  logic         busy;
  logic         err;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  latch_mutex_arbiter #(
    .N(N), .SYNC_STAGES(SS), .GUARD(GD), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .err_clr(err_clr),
    .gnt(gnt), .owner(owner), .busy(busy), .err(err)
  );

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic unexp(string nm, logic [31:0] got);
    compared++;
    mismatched++;
    $display("FAIL %s: got %0h expected nothing", nm, got);
  endtask

  // reference model: grant order, hold lengths and err transitions
  int           gq[$];
  int           lq[$];
  int           eq[$];
  logic [N-1:0] hist[$];
  logic [N-1:0] m_rs;
  int           m_act, m_held, m_cool, m_ptr;
  bit           m_rev, m_err, m_tmo;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist = {};
      for (int i = 0; i < SS; i++) hist.push_back('0);
      m_act = -1; m_held = 0; m_cool = 0; m_ptr = 0;
      m_rev = 0; m_err = 0;
      gq = {}; lq = {}; eq = {};
    end else begin
      m_rs = hist.pop_front();
      hist.push_back(req);
      m_tmo = 0;
      if (m_act >= 0) begin
        if (!m_rs[m_act]) begin
          if (!m_rev) lq.push_back(m_held + 1);
          m_act = -1;
          m_cool = GD;
        end else if (!m_rev) begin
          m_held++;
          if (m_held == TO) begin
            m_rev = 1; m_tmo = 1;
            lq.push_back(TO);
          end
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (m_rs != 0) begin
        for (int k = 0; k < N; k++)
          if (m_act < 0 && m_rs[(m_ptr + k) % N]) m_act = (m_ptr + k) % N;
        m_ptr = (m_act + 1) % N;
        m_held = 0; m_rev = 0;
        gq.push_back(m_act);
      end
      if (m_tmo) begin
        if (!m_err) eq.push_back(1);
        m_err = 1;
      end else if (err_clr && m_err) begin
        m_err = 0;
        eq.push_back(0);
      end
    end
  end

  // monitor: pops expectations whenever the DUT output changes
  logic [N-1:0] p_gnt;
  logic         p_err;
  int           hcnt;
  int           m_e;

  always @(negedge clk) begin
    if (!rst) begin
      p_gnt = '0; p_err = 0; hcnt = 0;
    end else begin
      chk("sb_onehot", 32'($countones(gnt) <= 1), 1);
      if (p_gnt == 0 && gnt != 0) begin
        if (gq.size() == 0) unexp("sb_unexp_grant", gnt);
        else begin
          m_e = gq.pop_front();
          chk("sb_grant", gnt, 32'(1) << m_e);
          chk("sb_owner", owner, m_e);
        end
      end
      if (gnt != 0) hcnt++;
      if (p_gnt != 0 && gnt == 0) begin
        if (lq.size() == 0) unexp("sb_unexp_release", hcnt);
        else chk("sb_hold_len", hcnt, lq.pop_front());
        hcnt = 0;
      end
      if (err !== p_err) begin
        if (eq.size() == 0) unexp("sb_unexp_err", err);
        else chk("sb_err", err, eq.pop_front());
      end
      p_gnt = gnt;
      p_err = err;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic wait_rise(output bit ok, input int maxc);
    ok = 0;
    for (int c = 0; c < maxc && !ok; c++) begin
      @(posedge clk); #1;
      if (gnt != 0) ok = 1;
    end
  endtask

  task automatic wait_fall(output bit ok, input int maxc);
    ok = 0;
    for (int c = 0; c < maxc && !ok; c++) begin
      @(posedge clk); #1;
      if (gnt == 0) ok = 1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  bit           ok, seen;
  int           hc, e;
  int           order[$], gaps[$];
  int           cnt[N], w[N], h[N];
  bit           g[N];
  logic [N-1:0] pg;
  int           fall_t;

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_owner", owner, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    #2 rst = 1'b1;

    // single request latency and release latency
    @(negedge clk) req = 4'b0001;
    @(posedge clk); #1 chk("t1_e1", gnt, 0);
    @(posedge clk); #1 chk("t1_e2", gnt, 0);
    @(posedge clk); #1 chk("t1_e3_gnt", gnt, 4'b0001);
    chk("t1_owner", owner, 0);
    chk("t1_busy", busy, 1);
    @(negedge clk) req = 4'b0000;
    @(posedge clk);
    @(posedge clk); #1 chk("t1_rel_e2", gnt, 4'b0001);
    @(posedge clk); #1 chk("t1_rel_e3", gnt, 0);
    chk("t1_busy_guard", busy, 1);
    @(posedge clk); #1 chk("t1_busy_idle", busy, 0);

    // all four requesting from reset release
    req = 4'b1111;
    do_reset();
    order = {}; gaps = {}; fall_t = -1; pg = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int c = 0; c < 200 && !(order.size() == 4 && gnt == 0 && req == 0); c++) begin
      @(negedge clk);
      if (gnt != 0 && pg == 0) begin
        order.push_back(int'(owner));
        if (fall_t >= 0) gaps.push_back(c - fall_t);
      end
      if (gnt == 0 && pg != 0) fall_t = c;
      for (int i = 0; i < N; i++) if (gnt[i]) begin
        cnt[i]++;
        if (cnt[i] == 5) req[i] = 1'b0;
      end
      pg = gnt;
    end
    chk("t2_count", order.size(), 4);
    foreach (order[k]) chk("t2_order", order[k], k);
    chk("t2_gap_count", gaps.size(), 3);
    foreach (gaps[k]) chk("t2_gap", gaps[k], GD + 1);
    req = '0;

    // round robin after owner 2
    do_reset();
    @(negedge clk) req = 4'b0100;
    wait_rise(ok, 20); chk("t3_wait1", ok, 1);
    chk("t3_g2", gnt, 4'b0100);
    repeat (3) @(posedge clk);
    req = 4'b0000;
    wait_fall(ok, 20); chk("t3_wait2", ok, 1);
    req = 4'b1010;
    wait_rise(ok, 20); chk("t3_wait3", ok, 1);
    chk("t3_g3_first", gnt, 4'b1000);
    req[3] = 1'b0;
    wait_fall(ok, 20); chk("t3_wait4", ok, 1);
    wait_rise(ok, 20); chk("t3_wait5", ok, 1);
    chk("t3_g1_next", gnt, 4'b0010);
    req = '0;
    wait_fall(ok, 20);

    // timeout revoke with a waiting requester
    do_reset();
    @(negedge clk) req = 4'b0010;
    wait_rise(ok, 20); chk("t4_wait1", ok, 1);
    chk("t4_g1", gnt, 4'b0010);
    req[2] = 1'b1;
    hc = 0;
    while (gnt[1] && hc < 40) begin
      @(posedge clk); #1;
      hc++;
    end
    chk("t4_hold", hc, TO);
    chk("t4_err", err, 1);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (gnt != 0) seen = 1;
    end
    chk("t4_no_grant", seen, 0);
    req[1] = 1'b0;
    e = 0;
    do begin
      @(posedge clk); #1;
      e++;
    end while (gnt == 0 && e < 30);
    chk("t4_regrant_lat", e, SS + 1 + GD + 1);
    chk("t4_g2", gnt, 4'b0100);
    req = '0;
    wait_fall(ok, 20);

    // err_clr coinciding with timeout, then one cycle later
    do_reset();
    @(negedge clk) req = 4'b0010;
    wait_rise(ok, 20); chk("t5_wait", ok, 1);
    repeat (TO - 1) @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk); #1;
    chk("t5_revoked", gnt, 0);
    chk("t5_set_wins", err, 1);
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("t5_cleared", err, 0);
    req = '0;
    repeat (6) @(posedge clk);

    // async reset while owner 2 holds
    do_reset();
    @(negedge clk) req = 4'b0100;
    wait_rise(ok, 20); chk("t6_wait1", ok, 1);
    @(posedge clk);
    #3 rst = 1'b0;
    req = 4'b1001;
    #1;
    chk("t6_gnt_async", gnt, 0);
    chk("t6_owner", owner, 0);
    chk("t6_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    wait_rise(ok, 20); chk("t6_wait2", ok, 1);
    chk("t6_g0_first", gnt, 4'b0001);
    req = '0;
    wait_fall(ok, 20);

    // random requester agents
    do_reset();
    for (int i = 0; i < N; i++) begin
      w[i] = $urandom_range(0, 5); h[i] = 0; g[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if (w[i] > 0) w[i]--;
          else begin req[i] = 1'b1; g[i] = 0; end
        end else if (!g[i]) begin
          if (gnt[i]) begin
            g[i] = 1; h[i] = $urandom_range(1, 12);
          end else if ($urandom_range(0, 39) == 0) begin
            req[i] = 1'b0; w[i] = $urandom_range(0, 6);
          end
        end else begin
          if (h[i] > 0) h[i]--;
          if (h[i] == 0) begin
            req[i] = 1'b0; w[i] = $urandom_range(0, 8);
          end
        end
      end
      err_clr = ($urandom_range(0, 29) == 0);
    end
    @(negedge clk);
    req = '0;
    err_clr = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk); #1;
    chk("drain_grants", gq.size(), 0);
    chk("drain_releases", lq.size(), 0);
    chk("drain_err", eq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
